// File: rtl/pipe_pkg.sv
// Shared pipeline decode constants and the multdiv sequencing state type
// used by the hazard controller and its load-use detector.
package pipe_pkg;

  localparam logic [4:0] OP_ALU = 5'b00000;
  localparam logic [4:0] OP_LW  = 5'b01000;
  localparam logic [4:0] OP_SW  = 5'b00111;
  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_JR  = 5'b00100;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int RD_MSB     = 26;
  localparam int RD_LSB     = 22;
  localparam int RS_MSB     = 21;
  localparam int RS_LSB     = 17;
  localparam int RT_MSB     = 16;
  localparam int RT_LSB     = 12;
  localparam int ALUOP_MSB  = 6;
  localparam int ALUOP_LSB  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the FD and DX latches.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic [31:0] fd_insn,
  input  logic [31:0] dx_insn,
  output logic        hazard
);

  logic [4:0] fd_op;
  logic [4:0] fd_rd;
  logic [4:0] fd_rs;
  logic [4:0] fd_rt;
  logic [4:0] dx_op;
  logic [4:0] dx_rd;
  logic       dx_is_load;
  logic       fd_is_rtype;
  logic       fd_reads_rd;
  logic       rs_match;
  logic       rt_match;
  logic       rd_match;
  logic       unused_insn_bits;

  assign fd_op = fd_insn[OPCODE_MSB:OPCODE_LSB];
  assign fd_rd = fd_insn[RD_MSB:RD_LSB];
  assign fd_rs = fd_insn[RS_MSB:RS_LSB];
  assign fd_rt = fd_insn[RT_MSB:RT_LSB];
  assign dx_op = dx_insn[OPCODE_MSB:OPCODE_LSB];
  assign dx_rd = dx_insn[RD_MSB:RD_LSB];

  assign dx_is_load  = (dx_op == OP_LW) && (dx_rd != 5'd0);
  assign fd_is_rtype = (fd_op == OP_ALU);
  // sw reads rd as store data, which the WM bypass supplies, so it is left out here.
  assign fd_reads_rd = (fd_op == OP_BNE) || (fd_op == OP_BLT) || (fd_op == OP_JR);

  assign rs_match = (fd_rs == dx_rd);
  assign rt_match = fd_is_rtype && (fd_rt == dx_rd);
  assign rd_match = fd_reads_rd && (fd_rd == dx_rd);

  assign hazard = dx_is_load && (rs_match || rt_match || rd_match);

  assign unused_insn_bits = ^{fd_insn[11:0], dx_insn[21:0]};

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush scheduler: load-use stalls, multdiv sequencing, branch flushes.
// Optional performance counters are enabled with `define HAZARD_PERF_EN.
module hazard_controller
  import pipe_pkg::*;
#(
  parameter int MD_MAX_CYCLES = 40,
  parameter int CNT_W         = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_insn,
  input  logic [31:0] dx_insn,
  input  logic        branch_taken,
  input  logic        md_ready,
  output logic        md_start,
  output logic        md_busy,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        nop_dx,
  output logic        nop_xm,
  output logic        flush_fd,
  output logic        md_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_md_stalls,
  output logic [31:0] perf_flushes
`endif
);

  md_state_t        state;
  md_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             lu_hazard;
  logic             dx_is_muldiv;

  load_use_detect u_load_use_detect (
    .fd_insn (fd_insn),
    .dx_insn (dx_insn),
    .hazard  (lu_hazard)
  );

  assign dx_is_muldiv = (dx_insn[OPCODE_MSB:OPCODE_LSB] == OP_ALU) &&
                        ((dx_insn[ALUOP_MSB:ALUOP_LSB] == ALU_MUL) ||
                         (dx_insn[ALUOP_MSB:ALUOP_LSB] == ALU_DIV));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    md_start   = 1'b0;
    md_busy    = 1'b0;
    stall_pc   = 1'b0;
    stall_fd   = 1'b0;
    stall_dx   = 1'b0;
    nop_dx     = 1'b0;
    nop_xm     = 1'b0;
    flush_fd   = 1'b0;
    md_timeout = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        // A mul/div sitting behind a taken branch is wrong-path and must not start.
        if (dx_is_muldiv && !branch_taken) begin
          md_start   = 1'b1;
          state_next = MD_BUSY;
        end
      end
      MD_BUSY: begin
        md_busy  = 1'b1;
        stall_pc = 1'b1;
        stall_fd = 1'b1;
        stall_dx = 1'b1;
        nop_xm   = 1'b1;
        cnt_next = cnt + CNT_W'(1);
        if (md_ready) begin
          state_next = MD_DONE;
        end else if (cnt == CNT_W'(MD_MAX_CYCLES - 1)) begin
          md_timeout = 1'b1;
          state_next = MD_DONE;
        end
      end
      MD_DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (state != MD_BUSY) begin
      if (branch_taken) begin
        flush_fd = 1'b1;
        nop_dx   = 1'b1;
      end else if (lu_hazard) begin
        stall_pc = 1'b1;
        stall_fd = 1'b1;
        nop_dx   = 1'b1;
      end
    end

    // Reset outranks every other request, including the combinational ones.
    if (reset) begin
      md_start   = 1'b0;
      md_busy    = 1'b0;
      stall_pc   = 1'b0;
      stall_fd   = 1'b0;
      stall_dx   = 1'b0;
      nop_dx     = 1'b0;
      nop_xm     = 1'b0;
      flush_fd   = 1'b0;
      md_timeout = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic lu_evt;

  assign lu_evt = stall_pc && !md_busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_lu_stalls <= '0;
      perf_md_stalls <= '0;
      perf_flushes   <= '0;
    end else begin
      if (lu_evt && (perf_lu_stalls != 32'hFFFF_FFFF)) begin
        perf_lu_stalls <= perf_lu_stalls + 32'd1;
      end
      if (md_busy && (perf_md_stalls != 32'hFFFF_FFFF)) begin
        perf_md_stalls <= perf_md_stalls + 32'd1;
      end
      if (flush_fd && (perf_flushes != 32'hFFFF_FFFF)) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: expected output vectors are queued
// as each cycle is driven and popped when that cycle's outputs are sampled.
module tb_hazard_controller;

  logic        clock;
  logic        reset;
  logic [31:0] fd_insn;
  logic [31:0] dx_insn;
  logic        branch_taken;
  logic        md_ready;
  logic        md_start;
  logic        md_busy;
  logic        stall_pc;
  logic        stall_fd;
  logic        stall_dx;
  logic        nop_dx;
  logic        nop_xm;
  logic        flush_fd;
  logic        md_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_stalls;
  logic [31:0] perf_md_stalls;
  logic [31:0] perf_flushes;
`endif

  int checks;
  int failures;
  int tally_lu;
  int tally_md;
  int tally_fl;

  // Output vector: {md_start, md_busy, stall_pc, stall_fd, stall_dx, nop_dx, nop_xm, flush_fd, md_timeout}
  localparam logic [8:0] E_NONE    = 9'h000;
  localparam logic [8:0] E_LU      = 9'h068;
  localparam logic [8:0] E_START   = 9'h100;
  localparam logic [8:0] E_BUSY    = 9'h0F4;
  localparam logic [8:0] E_TIMEOUT = 9'h0F5;
  localparam logic [8:0] E_FLUSH   = 9'h00A;

  localparam logic [4:0] T_ALU = 5'b00000;
  localparam logic [4:0] T_LW  = 5'b01000;
  localparam logic [4:0] T_SW  = 5'b00111;
  localparam logic [4:0] T_BNE = 5'b00010;
  localparam logic [4:0] T_IMM = 5'b00101;
  localparam logic [4:0] T_MUL = 5'b00110;
  localparam logic [4:0] T_DIV = 5'b00111;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  typedef struct {
    logic [31:0] fd;
    logic [31:0] dx;
    logic        br;
    logic        rdy;
    logic        rst;
    logic [8:0]  exp;
  } vec_t;

  logic [8:0] exp_q[$];

  hazard_controller dut (
    .clock        (clock),
    .reset        (reset),
    .fd_insn      (fd_insn),
    .dx_insn      (dx_insn),
    .branch_taken (branch_taken),
    .md_ready     (md_ready),
    .md_start     (md_start),
    .md_busy      (md_busy),
    .stall_pc     (stall_pc),
    .stall_fd     (stall_fd),
    .stall_dx     (stall_dx),
    .nop_dx       (nop_dx),
    .nop_xm       (nop_xm),
    .flush_fd     (flush_fd),
    .md_timeout   (md_timeout)
`ifdef HAZARD_PERF_EN
    ,
    .perf_lu_stalls (perf_lu_stalls),
    .perf_md_stalls (perf_md_stalls),
    .perf_flushes   (perf_flushes)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL sim_watchdog time=%0t limit=100000", $time);
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] aluop);
    return {op, rd, rs, rt, 5'd0, aluop, 2'd0};
  endfunction

  function automatic vec_t mk(input logic [31:0] fd, input logic [31:0] dx, input logic br,
                              input logic rdy, input logic rst, input logic [8:0] exp);
    vec_t v;
    v.fd = fd; v.dx = dx; v.br = br; v.rdy = rdy; v.rst = rst; v.exp = exp;
    return v;
  endfunction

  function automatic logic [8:0] outs_now();
    return {md_start, md_busy, stall_pc, stall_fd, stall_dx, nop_dx, nop_xm, flush_fd, md_timeout};
  endfunction

  // Drives one cycle's inputs after the falling edge, queues its expected
  // outputs and leaves time for the combinational outputs to settle.
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    fd_insn      = v.fd;
    dx_insn      = v.dx;
    branch_taken = v.br;
    md_ready     = v.rdy;
    reset        = v.rst;
    exp_q.push_back(v.exp);
    if (v.rst) begin
      tally_lu = 0; tally_md = 0; tally_fl = 0;
    end else begin
      if (v.exp[6] && !v.exp[7]) tally_lu++;
      if (v.exp[7]) tally_md++;
      if (v.exp[1]) tally_fl++;
    end
    #2;
  endtask

  task automatic test_reset();
    vec_t v[$];
    logic [8:0] got, exp;
    v.push_back(mk(NOP, enc(T_ALU, 6, 1, 2, T_MUL), 1'b0, 1'b0, 1'b1, E_NONE));
    v.push_back(mk(NOP, enc(T_ALU, 6, 1, 2, T_MUL), 1'b0, 1'b0, 1'b1, E_NONE));
    v.push_back(mk(NOP, NOP, 1'b0, 1'b0, 1'b0, E_NONE));
    for (int i = 0; i < v.size(); i++) begin
      applyStimulus(v[i]);
      got = outs_now();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL reset[%0d] outs=%09b expected=%09b", i, got, exp);
      end
    end
  endtask

  task automatic test_load_use();
    vec_t v[$];
    logic [8:0] got, exp;
    logic [31:0] lw5;
    lw5 = enc(T_LW, 5, 2, 0, 0);
    v.push_back(mk(enc(T_ALU, 3, 5, 2, 0), lw5, 1'b0, 1'b0, 1'b0, E_LU));
    v.push_back(mk(enc(T_ALU, 3, 5, 2, 0), NOP, 1'b0, 1'b0, 1'b0, E_NONE));
    v.push_back(mk(enc(T_ALU, 3, 2, 5, 0), lw5, 1'b0, 1'b0, 1'b0, E_LU));
    v.push_back(mk(enc(T_BNE, 5, 1, 0, 0), lw5, 1'b0, 1'b0, 1'b0, E_LU));
    v.push_back(mk(enc(T_ALU, 3, 1, 2, 0), lw5, 1'b0, 1'b0, 1'b0, E_NONE));
    v.push_back(mk(enc(T_IMM, 3, 1, 5, 0), lw5, 1'b0, 1'b0, 1'b0, E_NONE));
    v.push_back(mk(enc(T_ALU, 5, 1, 2, 0), lw5, 1'b0, 1'b0, 1'b0, E_NONE));
    v.push_back(mk(NOP, NOP, 1'b0, 1'b0, 1'b0, E_NONE));
    for (int i = 0; i < v.size(); i++) begin
      applyStimulus(v[i]);
      got = outs_now();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL load_use[%0d] outs=%09b expected=%09b", i, got, exp);
      end
    end
  endtask

  task automatic test_store_exempt();
    vec_t v[$];
    logic [8:0] got, exp;
    logic [31:0] lw5;
    lw5 = enc(T_LW, 5, 2, 0, 0);
    v.push_back(mk(enc(T_SW, 5, 2, 0, 0), lw5, 1'b0, 1'b0, 1'b0, E_NONE));
    v.push_back(mk(enc(T_SW, 2, 5, 0, 0), lw5, 1'b0, 1'b0, 1'b0, E_LU));
    v.push_back(mk(enc(T_SW, 2, 5, 0, 0), NOP, 1'b0, 1'b0, 1'b0, E_NONE));
    v.push_back(mk(enc(T_ALU, 1, 0, 0, 0), enc(T_LW, 0, 2, 0, 0), 1'b0, 1'b0, 1'b0, E_NONE));
    for (int i = 0; i < v.size(); i++) begin
      applyStimulus(v[i]);
      got = outs_now();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL store_r0[%0d] outs=%09b expected=%09b", i, got, exp);
      end
    end
  endtask

  task automatic test_multdiv_normal();
    vec_t v[$];
    logic [8:0] got, exp;
    logic [31:0] mul;
    int starts;
    mul = enc(T_ALU, 6, 1, 2, T_MUL);
    starts = 0;
    v.push_back(mk(NOP, mul, 1'b0, 1'b0, 1'b0, E_START));
    for (int c = 1; c <= 16; c++) v.push_back(mk(NOP, mul, 1'b0, 1'b0, 1'b0, E_BUSY));
    v.push_back(mk(NOP, mul, 1'b0, 1'b1, 1'b0, E_BUSY));
    v.push_back(mk(NOP, mul, 1'b0, 1'b1, 1'b0, E_NONE));
    v.push_back(mk(NOP, NOP, 1'b0, 1'b0, 1'b0, E_NONE));
    v.push_back(mk(NOP, NOP, 1'b0, 1'b0, 1'b0, E_NONE));
    for (int i = 0; i < v.size(); i++) begin
      applyStimulus(v[i]);
      got = outs_now();
      if (md_start === 1'b1) starts++;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL md_normal[%0d] outs=%09b expected=%09b", i, got, exp);
      end
    end
    checks++;
    if (starts !== 1) begin
      failures++;
      $display("[TB] FAIL md_normal_starts count=%0d expected=1", starts);
    end
  endtask

  task automatic test_watchdog();
    vec_t v[$];
    logic [8:0] got, exp;
    logic [31:0] dv;
    int timeouts;
    dv = enc(T_ALU, 7, 3, 4, T_DIV);
    timeouts = 0;
    v.push_back(mk(NOP, dv, 1'b0, 1'b0, 1'b0, E_START));
    for (int c = 1; c <= 39; c++) v.push_back(mk(NOP, dv, 1'b0, 1'b0, 1'b0, E_BUSY));
    v.push_back(mk(NOP, dv, 1'b0, 1'b0, 1'b0, E_TIMEOUT));
    v.push_back(mk(NOP, dv, 1'b0, 1'b0, 1'b0, E_NONE));
    v.push_back(mk(NOP, NOP, 1'b0, 1'b1, 1'b0, E_NONE));
    for (int i = 0; i < v.size(); i++) begin
      applyStimulus(v[i]);
      got = outs_now();
      if (md_timeout === 1'b1) timeouts++;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL watchdog[%0d] outs=%09b expected=%09b", i, got, exp);
      end
    end
    checks++;
    if (timeouts !== 1) begin
      failures++;
      $display("[TB] FAIL watchdog_pulses count=%0d expected=1", timeouts);
    end
  endtask

  task automatic test_flush_reset();
    vec_t v[$];
    logic [8:0] got, exp;
    logic [31:0] mul;
    int starts;
    mul = enc(T_ALU, 6, 1, 2, T_MUL);
    starts = 0;
    v.push_back(mk(enc(T_ALU, 3, 5, 2, 0), enc(T_LW, 5, 2, 0, 0), 1'b1, 1'b0, 1'b0, E_FLUSH));
    v.push_back(mk(NOP, mul, 1'b1, 1'b0, 1'b0, E_FLUSH));
    v.push_back(mk(NOP, NOP, 1'b0, 1'b0, 1'b0, E_NONE));
    v.push_back(mk(NOP, mul, 1'b0, 1'b0, 1'b0, E_START));
    for (int c = 1; c <= 4; c++) v.push_back(mk(NOP, mul, 1'b0, 1'b0, 1'b0, E_BUSY));
    v.push_back(mk(NOP, mul, 1'b0, 1'b0, 1'b1, E_NONE));
    v.push_back(mk(NOP, NOP, 1'b0, 1'b1, 1'b0, E_NONE));
    v.push_back(mk(NOP, NOP, 1'b0, 1'b0, 1'b0, E_NONE));
    for (int i = 0; i < v.size(); i++) begin
      applyStimulus(v[i]);
      got = outs_now();
      if (md_start === 1'b1) starts++;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL flush_reset[%0d] outs=%09b expected=%09b", i, got, exp);
      end
    end
    checks++;
    if (starts !== 1) begin
      failures++;
      $display("[TB] FAIL flush_reset_starts count=%0d expected=1", starts);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    logic [8:0] got, exp;
    logic [31:0] mul;
    mul = enc(T_ALU, 6, 5, 5, T_MUL);
    v.push_back(mk(mul, enc(T_LW, 5, 2, 0, 0), 1'b0, 1'b0, 1'b0, E_LU));
    v.push_back(mk(mul, NOP, 1'b0, 1'b0, 1'b0, E_NONE));
    v.push_back(mk(NOP, mul, 1'b0, 1'b0, 1'b0, E_START));
    v.push_back(mk(NOP, mul, 1'b0, 1'b1, 1'b0, E_BUSY));
    v.push_back(mk(NOP, mul, 1'b0, 1'b0, 1'b0, E_NONE));
    v.push_back(mk(NOP, NOP, 1'b0, 1'b0, 1'b0, E_NONE));
    for (int i = 0; i < v.size(); i++) begin
      applyStimulus(v[i]);
      got = outs_now();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL back_to_back[%0d] outs=%09b expected=%09b", i, got, exp);
      end
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    applyStimulus(mk(NOP, NOP, 1'b0, 1'b0, 1'b0, E_NONE));
    void'(exp_q.pop_front());
    checks++;
    if (perf_lu_stalls !== 32'(tally_lu)) begin
      failures++;
      $display("[TB] FAIL perf_lu got=%0d expected=%0d", perf_lu_stalls, tally_lu);
    end
    checks++;
    if (perf_md_stalls !== 32'(tally_md)) begin
      failures++;
      $display("[TB] FAIL perf_md got=%0d expected=%0d", perf_md_stalls, tally_md);
    end
    checks++;
    if (perf_flushes !== 32'(tally_fl)) begin
      failures++;
      $display("[TB] FAIL perf_flush got=%0d expected=%0d", perf_flushes, tally_fl);
    end
  endtask
`endif

  initial begin
    checks       = 0;
    failures     = 0;
    tally_lu     = 0;
    tally_md     = 0;
    tally_fl     = 0;
    reset        = 1'b1;
    fd_insn      = NOP;
    dx_insn      = NOP;
    branch_taken = 1'b0;
    md_ready     = 1'b0;

    $display("[TB] starting hazard_controller bench");
    test_reset();
    test_load_use();
    test_store_exempt();
    test_multdiv_normal();
    test_watchdog();
    test_back_to_back();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    test_flush_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
